// File: rtl/fetch_unit.sv
// fetch_unit: RV32 instruction fetch with variable-latency memory handshake and IF/ID register
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemReady,
  input  logic [31:0] ImemRdata,
  output logic        FetchBusyF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);
  typedef enum logic [1:0] {FETCH, DISCARD, HOLD} state_t;
  state_t state;
  logic [31:0] pcF, redirPC, bufWord, targetE, fetchWord;
  logic deliver;
  assign targetE    = PCTargetE & 32'hFFFFFFFC;
  assign ImemReq    = state != HOLD;
  assign ImemAddr   = pcF;
  assign FetchBusyF = (state == FETCH && !ImemReady) || state == DISCARD;
  // a redirect always suppresses delivery; a stall parks the word in HOLD instead
  assign deliver    = !PCSrcE && !StallF && ((state == FETCH && ImemReady) || state == HOLD);
  assign fetchWord  = state == HOLD ? bufWord : ImemRdata;
  always_ff @(posedge clk) begin
    if (reset) begin
      pcF     <= RESET_PC;
      state   <= FETCH;
      redirPC <= '0;
      bufWord <= '0;
    end else begin
      case (state)
        FETCH:
          if (!ImemReady) begin
            if (PCSrcE) begin
              redirPC <= targetE;
              state   <= DISCARD;
            end
          end else if (PCSrcE) pcF <= targetE;
          else if (StallF) begin
            bufWord <= ImemRdata;
            state   <= HOLD;
          end else pcF <= pcF + 32'd4;
        DISCARD:
          if (ImemReady) begin
            pcF   <= PCSrcE ? targetE : redirPC;
            state <= FETCH;
          end else if (PCSrcE) redirPC <= targetE;
        HOLD:
          if (PCSrcE) begin
            pcF   <= targetE;
            state <= FETCH;
          end else if (!StallF) begin
            pcF   <= pcF + 32'd4;
            state <= FETCH;
          end
        default: state <= FETCH;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset || FlushD) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (!StallD) begin
      InstrD   <= deliver ? fetchWord : NOP_INSTR;
      PCD      <= deliver ? pcF : '0;
      PCPlus4D <= deliver ? pcF + 32'd4 : '0;
      ValidD   <= deliver;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed cycle vectors plus randomized program-order scoreboard for fetch_unit
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h00000013;
  logic clk = 0, reset = 1, StallF = 0, StallD = 0, FlushD = 0, PCSrcE = 0, ImemReady = 0;
  logic [31:0] PCTargetE = 0, ImemRdata = 0;
  logic ImemReq, FetchBusyF, ValidD;
  logic [31:0] ImemAddr, InstrD, PCD, PCPlus4D;
  int total = 0, passed = 0;

  fetch_unit dut (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
    .ImemReady(ImemReady), .ImemRdata(ImemRdata), .FetchBusyF(FetchBusyF),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, rdy, sF, sD, fD, pcs;
    logic [31:0] rdata, tgt, eAddr;
    logic eReq, eBusy, eValid;
    logic [31:0] eInstr, ePcd;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic rdy, logic [31:0] rdata, logic sF, logic sD,
                              logic fD, logic pcs, logic [31:0] tgt, logic [31:0] eAddr,
                              logic eReq, logic eBusy, logic eValid, logic [31:0] eInstr,
                              logic [31:0] ePcd);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rdata = rdata; v.sF = sF; v.sD = sD; v.fD = fD;
    v.pcs = pcs; v.tgt = tgt; v.eAddr = eAddr; v.eReq = eReq; v.eBusy = eBusy;
    v.eValid = eValid; v.eInstr = eInstr; v.ePcd = ePcd;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  initial begin
    logic [31:0] expPC, lastInstr, lastPcd, lastPlus4, prevAddr;
    logic lastValid, prevWait;
    int waitCnt, lat, deliveries;
    vecs.push_back(mk(1,1,0,          0,0,0,0,0,           0,        1,0,0,NOP,0));
    vecs.push_back(mk(0,1,1,          0,0,0,0,0,           0,        1,0,1,1,0));
    vecs.push_back(mk(0,1,5,          0,0,0,0,0,           4,        1,0,1,5,4));
    vecs.push_back(mk(0,1,9,          0,0,0,0,0,           8,        1,0,1,9,8));
    vecs.push_back(mk(0,0,0,          0,0,0,0,0,           'hC,      1,1,0,NOP,0));
    vecs.push_back(mk(0,0,0,          0,0,0,0,0,           'hC,      1,1,0,NOP,0));
    vecs.push_back(mk(0,1,'hD,        0,0,0,0,0,           'hC,      1,0,1,'hD,'hC));
    vecs.push_back(mk(0,1,'h11,       0,0,1,1,'h103,       'h10,     1,0,0,NOP,0));
    vecs.push_back(mk(0,0,0,          0,0,1,1,'h200,       'h100,    1,1,0,NOP,0));
    vecs.push_back(mk(0,0,0,          0,0,0,0,0,           'h100,    1,1,0,NOP,0));
    vecs.push_back(mk(0,0,0,          0,0,1,1,'h300,       'h100,    1,1,0,NOP,0));
    vecs.push_back(mk(0,1,'h101,      0,0,0,0,0,           'h100,    1,1,0,NOP,0));
    vecs.push_back(mk(0,1,'h301,      0,0,0,0,0,           'h300,    1,0,1,'h301,'h300));
    vecs.push_back(mk(0,1,'hABC,      1,1,0,0,0,           'h304,    1,0,1,'h301,'h300));
    vecs.push_back(mk(0,0,0,          1,1,0,0,0,           'h304,    0,0,1,'h301,'h300));
    vecs.push_back(mk(0,0,0,          1,1,0,0,0,           'h304,    0,0,1,'h301,'h300));
    vecs.push_back(mk(0,0,0,          0,0,0,0,0,           'h304,    0,0,1,'hABC,'h304));
    vecs.push_back(mk(0,1,'h309,      0,0,0,0,0,           'h308,    1,0,1,'h309,'h308));
    vecs.push_back(mk(0,1,'h30D,      1,1,0,0,0,           'h30C,    1,0,1,'h309,'h308));
    vecs.push_back(mk(1,0,0,          1,1,1,0,0,           'h30C,    0,0,0,NOP,0));
    vecs.push_back(mk(0,0,0,          0,0,0,0,0,           0,        1,1,0,NOP,0));
    vecs.push_back(mk(0,1,1,          0,0,1,1,'hFFFFFFFE,  0,        1,0,0,NOP,0));
    vecs.push_back(mk(0,1,'hFFFFFFFD, 0,0,0,0,0,           'hFFFFFFFC,1,0,1,'hFFFFFFFD,'hFFFFFFFC));
    vecs.push_back(mk(0,1,1,          0,0,0,0,0,           0,        1,0,1,1,0));
    vecs.push_back(mk(0,1,5,          1,1,0,0,0,           4,        1,0,1,1,0));
    vecs.push_back(mk(0,0,0,          1,1,1,1,'h40,        4,        0,0,0,NOP,0));
    vecs.push_back(mk(0,1,'h41,       0,0,0,0,0,           'h40,     1,0,1,'h41,'h40));

    repeat (2) @(posedge clk);
    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; ImemReady = vecs[i].rdy; ImemRdata = vecs[i].rdata;
      StallF = vecs[i].sF; StallD = vecs[i].sD; FlushD = vecs[i].fD;
      PCSrcE = vecs[i].pcs; PCTargetE = vecs[i].tgt;
      #1;
      chk($sformatf("v%0d ImemAddr", i), ImemAddr, vecs[i].eAddr);
      chk($sformatf("v%0d ImemReq", i), 32'(ImemReq), 32'(vecs[i].eReq));
      chk($sformatf("v%0d FetchBusyF", i), 32'(FetchBusyF), 32'(vecs[i].eBusy));
      @(posedge clk); #1;
      chk($sformatf("v%0d ValidD", i), 32'(ValidD), 32'(vecs[i].eValid));
      chk($sformatf("v%0d InstrD", i), InstrD, vecs[i].eInstr);
      chk($sformatf("v%0d PCD", i), PCD, vecs[i].ePcd);
      chk($sformatf("v%0d PCPlus4D", i), PCPlus4D, vecs[i].eValid ? vecs[i].ePcd + 32'd4 : 32'd0);
    end

    // random phase: every newly delivered word must be the next instruction in program order
    @(negedge clk);
    reset = 1; ImemReady = 0; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0;
    @(posedge clk); #1;
    reset = 0;
    expPC = 0; waitCnt = 0; lat = $urandom_range(1, 4); deliveries = 0; prevWait = 0; prevAddr = 0;
    lastInstr = InstrD; lastPcd = PCD; lastPlus4 = PCPlus4D; lastValid = ValidD;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      StallF = ($urandom % 4) == 0;
      StallD = StallF && ($urandom % 2);
      PCSrcE = ($urandom % 16) == 0;
      FlushD = PCSrcE;
      PCTargetE = ($urandom % 8 == 0) ? (32'hFFFFFFF0 | 32'($urandom % 16)) : 32'($urandom % 1024);
      #1;
      ImemReady = ImemReq && (waitCnt >= lat - 1);
      ImemRdata = ImemReady ? (ImemAddr | 32'd1) : 32'hDEADBEEF;
      #1;
      if (prevWait) chk("rnd addr stable", ImemAddr, prevAddr);
      prevWait = ImemReq && !ImemReady;
      prevAddr = ImemAddr;
      @(posedge clk); #1;
      if (ImemReq && ImemReady) begin
        waitCnt = 0;
        lat = $urandom_range(1, 4);
      end else if (ImemReq) waitCnt++;
      if (FlushD) begin
        chk("rnd flush ValidD", 32'(ValidD), 0);
        chk("rnd flush InstrD", InstrD, NOP);
      end else if (StallD) begin
        chk("rnd stall InstrD", InstrD, lastInstr);
        chk("rnd stall PCD", PCD, lastPcd);
        chk("rnd stall PCPlus4D", PCPlus4D, lastPlus4);
        chk("rnd stall ValidD", 32'(ValidD), 32'(lastValid));
      end else if (ValidD) begin
        chk("rnd PCD order", PCD, expPC);
        chk("rnd InstrD", InstrD, expPC | 32'd1);
        chk("rnd PCPlus4D", PCPlus4D, expPC + 32'd4);
        expPC += 4;
        deliveries++;
      end else begin
        chk("rnd bubble InstrD", InstrD, NOP);
        chk("rnd bubble PCD", PCD, 0);
      end
      if (PCSrcE) expPC = PCTargetE & 32'hFFFFFFFC;
      lastInstr = InstrD; lastPcd = PCD; lastPlus4 = PCPlus4D; lastValid = ValidD;
    end
    chk("rnd progress", 32'(deliveries > 500), 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
